seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Purpose: serial stimulus transmitter for the team's "four equal bits" sequence-detector FSM. It drives the detector's w input and predicts the detector's z output.

Interface
REQ-001 Parameter PAT_W, default 16, pattern register width in bits.
REQ-002 Parameter REP_W, default 4, repeat-count width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin transmission; sampled only in IDLE.
REQ-006 pattern  input  PAT_W  bits to send, MSB-first, starting at bit len-1.
REQ-007 len  input  5  pattern length 1..16; value 0 SHALL mean 16.
REQ-008 reps  input  REP_W  number of passes; 0 SHALL mean continuous until stop.
REQ-009 stop  input  1  abort request, honoured in SEND.
REQ-010 w  output  1  serial bit to the detector.
REQ-011 w_valid  output  1  high while w carries a pattern bit.
REQ-012 busy  output  1  high in LOAD, SEND and DONE.
REQ-013 done  output  1  one-cycle pulse at end of transmission.
REQ-014 z_exp  output  1  predicted detector output.
REQ-015 state_code  output  4  state code for the HEX display: IDLE=0, LOAD=1, SEND=2, DONE=4.

Function
REQ-016 The state machine SHALL have four states: IDLE, LOAD, SEND and DONE.
REQ-017 In IDLE with start=1, the block SHALL move to LOAD on the next edge; otherwise it SHALL remain in IDLE.
REQ-018 LOAD SHALL last exactly one cycle.
REQ-019 LOAD SHALL capture pattern, effective len (0 becomes 16) and reps, clear the bit index and z history, and drive w_valid=0.
REQ-020 SEND SHALL drive one bit per cycle: w = pattern[len-1-idx], w_valid=1.
REQ-021 The first bit SHALL be valid two cycles after the edge that samples start.
REQ-022 After bit idx=len-1 of a pass, the next pass SHALL begin on the immediately following cycle, with no gap, if passes remain or reps=0.
REQ-023 After the last bit of the last pass, the block SHALL go to DONE.
REQ-024 A pass counter SHALL decrement once per completed pass; with reps=0 it SHALL be ignored.
REQ-025 stop=1 in SEND SHALL send the block to DONE on the next edge; the bit presented in that cycle still counts as sent.
REQ-026 stop outside SEND SHALL be ignored.
REQ-027 DONE SHALL last one cycle with done=1, w=0 and w_valid=0, then return to IDLE.
REQ-028 start while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-029 z_exp SHALL be registered; it is 1 in the cycle after the fourth or later consecutive equal valid bit, matching the detector's Moore latency.
REQ-030 z_exp SHALL drop to 0 in the cycle after a differing bit.
REQ-031 z_exp SHALL be 0 in LOAD, DONE and IDLE, except for the single DONE cycle immediately following a qualifying last bit.
REQ-032 The z history SHALL persist across pass boundaries.
REQ-033 Outside SEND, w SHALL be 0.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE regardless of the current state, including mid-SEND.
REQ-035 Reset SHALL force all outputs (w, w_valid, busy, done, z_exp, state_code) to 0 in the following cycle.
REQ-036 Reset SHALL clear the pass counter, bit index and z history.
REQ-037 Reset SHALL take priority over start and stop.

Verification
REQ-038 pattern=16'h00F0, len=8, reps=1, start pulse:
- w = 1,1,1,1,0,0,0,0 on cycles +2..+9.
- z_exp=1 on cycle +6 only during the ones run, and =1 on the DONE cycle (+10) after the fourth 0.
- done=1 on cycle +10.
REQ-039 pattern=16'h000A, len=4, reps=3:
- w = 101010101010 (12 bits, contiguous).
- z_exp stays 0.
- busy high for 14 cycles in total.
REQ-040 len=0, pattern=16'hFFFF, reps=1:
- 16 ones are sent.
- z_exp high from the 5th to the 17th cycle after LOAD.
REQ-041 reps=0, pattern=16'h0001, len=2 (w = 0,1 repeating), stop asserted on the 7th valid bit:
- exactly 7 bits are sent.
- DONE follows.
- start asserted while busy has no effect.
REQ-042 reset asserted on the 3rd bit of a transmission:
- next cycle shows state_code=0 and all outputs 0.
- a fresh start afterwards transmits from bit len-1.
REQ-043 Random patterns, lengths and reps with the detector FSM connected: detector z SHALL equal z_exp on every cycle.

Source files
------------

// File: rtl/seq_gen.sv
// seq_gen: serial stimulus transmitter for the "four equal bits" detector.
// Sends a captured pattern MSB-first (from bit len-1) for a number of passes
// and predicts the detector's registered Moore output on z_exp.
module seq_gen #(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [4:0]       len,
    input  logic [REP_W-1:0] reps,
    input  logic             stop,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             z_exp,
    output logic [3:0]       state_code
);

    // Encodings double as the HEX display state code.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        SEND = 4'd2,
        DONE = 4'd4
    } state_t;

    // Longest pattern the length field and pattern register can both describe.
    localparam int unsigned MAXL    = (PAT_W < 16) ? PAT_W : 16;
    localparam logic [4:0]  MAX_LEN = 5'(MAXL);

    state_t           state;
    state_t           state_nx;

    logic [PAT_W-1:0] pat_r;
    logic [4:0]       len_r;
    logic [REP_W-1:0] pass_cnt;
    logic             cont_r;
    logic [4:0]       idx;
    logic [2:0]       run;
    logic             last_bit;
    logic             z_r;

    logic [4:0]       len_eff;
    logic [4:0]       sel;
    logic             cur_bit;
    logic             pass_end;
    logic             last_pass;
    logic [2:0]       run_inc;

    // Effective length: zero (or anything too long) selects the maximum.
    always_comb begin
        len_eff = len;
        if (len == 5'd0 || len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    // Select the bit currently on the wire: pattern[len-1-idx].
    always_comb begin
        sel     = len_r - 5'd1 - idx;
        cur_bit = 1'b0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            if (sel == 5'(i)) begin
                cur_bit = pat_r[i];
            end
        end
    end

    // Pass bookkeeping and the run length after the bit now being sent.
    always_comb begin
        pass_end  = (idx == len_r - 5'd1);
        last_pass = !cont_r && (pass_cnt == REP_W'(1));
        if (run != 3'd0 && cur_bit == last_bit) begin
            run_inc = (run == 3'd4) ? 3'd4 : run + 3'd1;
        end else begin
            run_inc = 3'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nx = state;
        w        = 1'b0;
        w_valid  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                busy    = 1'b1;
                w       = cur_bit;
                w_valid = 1'b1;
                if (stop || (pass_end && last_pass)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture in LOAD, advance bit index / pass counter / z history in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r    <= '0;
            len_r    <= '0;
            pass_cnt <= '0;
            cont_r   <= 1'b0;
            idx      <= '0;
            run      <= '0;
            last_bit <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    pat_r    <= pattern;
                    len_r    <= len_eff;
                    pass_cnt <= reps;
                    cont_r   <= (reps == '0);
                    idx      <= '0;
                    run      <= '0;
                    last_bit <= 1'b0;
                end
                SEND: begin
                    // Run history spans pass boundaries; only LOAD/reset clear it.
                    run      <= run_inc;
                    last_bit <= cur_bit;
                    if (!stop) begin
                        if (pass_end) begin
                            idx <= '0;
                            if (!cont_r) begin
                                pass_cnt <= pass_cnt - REP_W'(1);
                            end
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered detector prediction: high the cycle after a 4th+ equal valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_r <= 1'b0;
        end else begin
            z_r <= (state == SEND) && (run_inc == 3'd4);
        end
    end

    assign z_exp      = z_r;
    assign state_code = state;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven transactions checked cycle by cycle through a
// scoreboard queue, plus a behavioural four-equal-bits detector on w.
module tb_seq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        w;
    logic        w_valid;
    logic        busy;
    logic        done;
    logic        z_exp;
    logic [3:0]  state_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_gen #(.PAT_W(16), .REP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .stop       (stop),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done),
        .z_exp      (z_exp),
        .state_code (state_code)
    );

    // Classic 9-state Moore detector; cleared whenever w is not carrying data.
    typedef enum logic [3:0] {DA, DB, DC, DD, DE, DF, DG, DH, DI} det_t;
    det_t det;
    logic det_z;

    always @(posedge clk) begin
        if (reset || !w_valid) det <= DA;
        else begin
            case (det)
                DA, DF: det <= w ? ((det == DF) ? DG : DF) : DB;
                DB:     det <= w ? DF : DC;
                DC:     det <= w ? DF : DD;
                DD, DE: det <= w ? DF : DE;
                DG:     det <= w ? DH : DB;
                DH, DI: det <= w ? DI : DB;
                default: det <= DA;
            endcase
        end
    end
    assign det_z = (det == DE) || (det == DI);

    typedef struct packed {
        logic       w;
        logic       wv;
        logic       busy;
        logic       done;
        logic       z;
        logic [3:0] sc;
    } exp_t;

    exp_t exp_q[$];

    // Inputs plus expected totals over the transaction (-1 = not tabulated).
    typedef struct {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [3:0]  reps;
        int          stop_at;
        bit          noise;
        int          e_bits;
        int          e_z;
        int          e_busy;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic w_i, input logic wv_i, input logic b_i,
                                input logic d_i, input logic z_i, input logic [3:0] sc_i);
        exp_t e;
        e.w = w_i; e.wv = wv_i; e.busy = b_i; e.done = d_i; e.z = z_i; e.sc = sc_i;
        return e;
    endfunction

    // Reference: expected outputs from the LOAD cycle through the IDLE cycle after DONE.
    task automatic push_expected(input txn_t t);
        int   l;
        int   nb;
        int   run;
        logic last;
        logic zr;
        logic b;
        logic [15:0] p;
        l  = (t.len == 0) ? 16 : int'(t.len);
        nb = (t.reps == 0) ? t.stop_at : int'(t.reps) * l;
        if (t.stop_at > 0 && t.stop_at < nb) nb = t.stop_at;
        p    = t.pat;
        run  = 0;
        last = 1'b0;
        zr   = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1));
        for (int i = 0; i < nb; i++) begin
            b = p[l - 1 - (i % l)];
            exp_q.push_back(mk(b, 1'b1, 1'b1, 1'b0, zr, 4'd2));
            if (run > 0 && b == last) run = (run >= 4) ? 4 : run + 1;
            else run = 1;
            last = b;
            zr   = (run >= 4);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, zr, 4'd4));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    endtask

    task automatic check_cycle();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got no expected entry at t=%0t", $time);
            return;
        end
        e = exp_q.pop_front();
        chk("w",          w,          e.w);
        chk("w_valid",    w_valid,    e.wv);
        chk("busy",       busy,       e.busy);
        chk("done",       done,       e.done);
        chk("z_exp",      z_exp,      e.z);
        chk("state_code", state_code, e.sc);
        chk("z_det",      det_z,      z_exp);
    endtask

    // Entry: just after an active edge, DUT idle. Exit: same.
    task automatic run_txn(input txn_t t);
        int n;
        int c_bits;
        int c_z;
        int c_busy;
        push_expected(t);
        n = exp_q.size();
        c_bits = 0; c_z = 0; c_busy = 0;
        pattern = t.pat;
        len     = t.len;
        reps    = t.reps;
        start   = 1'b1;
        stop    = t.noise;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = t.noise;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_cycle();
            c_bits += int'(w_valid);
            c_z    += int'(z_exp);
            c_busy += int'(busy);
            @(posedge clk); #1;
            // Inputs for cycle k+1; pattern/len/reps are scrambled after capture.
            pattern = 16'($urandom);
            len     = 5'($urandom);
            reps    = 4'($urandom);
            stop    = (t.stop_at > 0 && k == t.stop_at) || (t.noise && k + 1 == n - 1);
            start   = t.noise && (k + 1 >= 2) && (k + 1 <= n - 1);
        end
        start = 1'b0;
        stop  = 1'b0;
        if (t.e_bits >= 0) chk("n_bits", c_bits, t.e_bits);
        if (t.e_z >= 0)    chk("n_z",    c_z,    t.e_z);
        if (t.e_busy >= 0) chk("n_busy", c_busy, t.e_busy);
    endtask

    txn_t tbl[12];

    initial begin
        txn_t t;
        int   l;
        tbl[0] = '{16'h00F0, 5'd8,  4'd1, 0, 1'b0,  8,  2, 10};
        tbl[1] = '{16'h000A, 5'd4,  4'd3, 0, 1'b0, 12,  0, 14};
        tbl[2] = '{16'hFFFF, 5'd0,  4'd1, 0, 1'b0, 16, 13, 18};
        tbl[3] = '{16'h0001, 5'd2,  4'd0, 7, 1'b1,  7,  0,  9};
        tbl[4] = '{16'h0001, 5'd1,  4'd5, 0, 1'b1,  5,  2,  7};
        tbl[5] = '{16'h000F, 5'd4,  4'd2, 1, 1'b0,  1,  0,  3};
        for (int i = 6; i < 12; i++) begin
            tbl[i].pat   = 16'($urandom);
            tbl[i].len   = 5'($urandom_range(0, 16));
            tbl[i].reps  = 4'($urandom_range(0, 3));
            l = (tbl[i].len == 0) ? 16 : int'(tbl[i].len);
            if (tbl[i].reps == 0) tbl[i].stop_at = $urandom_range(1, 40);
            else if ($urandom_range(0, 3) == 0) tbl[i].stop_at = $urandom_range(1, int'(tbl[i].reps) * l);
            else tbl[i].stop_at = 0;
            tbl[i].noise  = 1'($urandom);
            tbl[i].e_bits = -1;
            tbl[i].e_z    = -1;
            tbl[i].e_busy = -1;
        end

        // Reset with start/stop asserted: reset must win.
        reset   = 1'b1;
        start   = 1'b1;
        stop    = 1'b1;
        pattern = 16'hFFFF;
        len     = 5'd4;
        reps    = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w",       w,          1'b0);
        chk("rst_w_valid", w_valid,    1'b0);
        chk("rst_busy",    busy,       1'b0);
        chk("rst_done",    done,       1'b0);
        chk("rst_z",       z_exp,      1'b0);
        chk("rst_sc",      state_code, 4'd0);
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // Reset on the 3rd bit, then a fresh transmission from bit len-1.
        t = '{16'h00B5, 5'd8, 4'd2, 0, 1'b0, 16, -1, 18};
        push_expected(t);
        pattern = t.pat;
        len     = t.len;
        reps    = t.reps;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk); #1;
            if (k == 3) begin
                reset = 1'b1;
                start = 1'b1;
                stop  = 1'b1;
            end
        end
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst3_w",       w,          1'b0);
        chk("rst3_w_valid", w_valid,    1'b0);
        chk("rst3_busy",    busy,       1'b0);
        chk("rst3_done",    done,       1'b0);
        chk("rst3_z",       z_exp,      1'b0);
        chk("rst3_sc",      state_code, 4'd0);
        @(posedge clk); #1;
        run_txn(t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
